// File: rtl/bp_gshare_pkg.sv
// Shared types and constants for the gshare branch predictor.
// Holds the EX-side predictor packet, 2-bit counter encodings and BTB entry.
`ifndef XLEN
`define XLEN 32
`endif

package bp_gshare_pkg;

  localparam int XLEN         = `XLEN;
  localparam int BP_GHR_W     = 8;
  localparam int BP_BTB_TAG_W = 10;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  typedef struct packed {
    logic [BP_GHR_W-1:0] ex_ghr;
    logic                ex_mispredict;
  } ex_bp_packet_t;

  typedef struct packed {
    logic                    valid;
    logic [BP_BTB_TAG_W-1:0] tag;
    logic [XLEN-1:0]         target;
  } btb_entry_t;

  function automatic logic [1:0] ctr_next(
    input logic [1:0] c,
    input logic       up
  );
    logic [1:0] n;
    n = c;
    if (up && c != ST)
      n = c + 2'd1;
    else if (!up && c != SNT)
      n = c - 2'd1;
    return n;
  endfunction

endpackage

// File: rtl/bp_ras.sv
// Circular return-address stack; overflow overwrites the oldest entry.
// Ports: clock/reset, push/pop strobes, push_pc in, top_pc/valid out.
module bp_ras
  import bp_gshare_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_pc,
  output logic [XLEN-1:0] top_pc,
  output logic            valid
);

  localparam int PW = $clog2(DEPTH);

  logic [XLEN-1:0] stack [DEPTH];
  logic [PW-1:0]   tos;
  logic [PW:0]     cnt;
  logic            do_pop;

  assign do_pop = pop && (cnt != '0);
  assign valid  = cnt != '0;
  assign top_pc = stack[tos];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tos <= '0;
      cnt <= '0;
    end else if (do_pop && push) begin
      // pop then push: top is replaced in place
      tos <= tos;
    end else if (do_pop) begin
      tos <= tos - 1'b1;
      cnt <= cnt - 1'b1;
    end else if (push) begin
      tos <= tos + 1'b1;
      if (cnt != (PW+1)'(DEPTH))
        cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push)
      stack[do_pop ? tos : tos + 1'b1] <= push_pc;
  end

endmodule

// File: rtl/bp_gshare.sv
// Gshare predictor: GHR-xor-PC indexed PHT, tagged BTB, optional RAS (BP_RAS_EN).
// Ports: if_* fetch query -> bp_* prediction; ex_* resolution trains and repairs.
module bp_gshare
  import bp_gshare_pkg::*;
#(
  parameter int PHT_IDX_W = 8,
  parameter int GHR_W     = BP_GHR_W,
  parameter int BTB_IDX_W = 5,
  parameter int BTB_TAG_W = BP_BTB_TAG_W,
  parameter int RAS_DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             if_valid,
  input  logic [XLEN-1:0]  if_pc,
  input  logic             if_cond_br,
  input  logic             if_jump,
  input  logic             if_call,
  input  logic             if_ret,
  output logic [XLEN-1:0]  bp_pc,
  output logic [XLEN-1:0]  bp_npc,
  output logic             bp_taken,
  output logic [GHR_W-1:0] bp_ghr,
  input  logic             ex_valid,
  input  logic             ex_cond,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic             ex_taken,
  input  logic [XLEN-1:0]  ex_tg_pc,
  input  logic [GHR_W-1:0] ex_ghr,
  input  logic             ex_mispredict
);

  localparam int PHT_N = 1 << PHT_IDX_W;
  localparam int BTB_N = 1 << BTB_IDX_W;
  localparam int TAG_LO = BTB_IDX_W + 2;
  localparam int TAG_HI = BTB_IDX_W + BTB_TAG_W + 1;

  typedef struct packed {
    logic                 valid;
    logic [BTB_TAG_W-1:0] tag;
    logic [XLEN-1:0]      target;
  } btb_ent_t;

  logic [1:0]       pht [PHT_N];
  btb_ent_t         btb [BTB_N];
  logic [GHR_W-1:0] ghr;

  logic [XLEN-1:0]      pc_seq;
  logic [PHT_IDX_W-1:0] rd_idx;
  logic [PHT_IDX_W-1:0] wr_idx;
  logic                 pred_dir;
  btb_ent_t             btb_rd;
  logic                 btb_hit;
  logic                 use_ras;
  logic                 is_jump;
  logic [XLEN-1:0]      ras_top;
  logic [XLEN-1:0]      tgt;
  logic                 tkn;
  logic                 unused_ok;

  assign pc_seq   = if_pc + XLEN'(4);
  assign rd_idx   = if_pc[PHT_IDX_W+1:2] ^ PHT_IDX_W'(ghr);
  assign wr_idx   = ex_pc[PHT_IDX_W+1:2] ^ PHT_IDX_W'(ex_ghr);
  assign pred_dir = pht[rd_idx][1];
  assign btb_rd   = btb[if_pc[BTB_IDX_W+1:2]];
  assign btb_hit  = btb_rd.valid &&
                    (btb_rd.tag == if_pc[TAG_HI:TAG_LO]);

`ifdef BP_RAS_EN
  logic ras_valid;

  bp_ras #(
    .DEPTH(RAS_DEPTH)
  ) u_ras (
    .clock  (clock),
    .reset  (reset),
    .push   (if_valid && if_call),
    .pop    (if_valid && if_ret),
    .push_pc(pc_seq),
    .top_pc (ras_top),
    .valid  (ras_valid)
  );

  assign use_ras   = if_ret && ras_valid;
  assign is_jump   = if_jump;
  assign unused_ok = ^{1'b0, ex_pc};
`else
  assign use_ras   = 1'b0;
  assign ras_top   = '0;
  // without a RAS a return is just an indirect jump looked up in the BTB
  assign is_jump   = if_jump || if_ret;
  assign unused_ok = ^{1'b0, ex_pc, if_call};
`endif

  always_comb begin
    tgt = pc_seq;
    tkn = 1'b0;
    if (!reset && if_valid) begin
      if (use_ras) begin
        tgt = ras_top;
        tkn = 1'b1;
      end else if (btb_hit && (is_jump || (if_cond_br && pred_dir))) begin
        tgt = btb_rd.target;
        tkn = 1'b1;
      end
    end
  end

  assign bp_pc    = tgt;
  assign bp_npc   = tgt + XLEN'(4);
  assign bp_taken = tkn;
  assign bp_ghr   = reset ? '0 : ghr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PHT_N; i++)
        pht[i] <= WNT;
    end else if (ex_valid && ex_cond) begin
      pht[wr_idx] <= ctr_next(pht[wr_idx], ex_taken);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BTB_N; i++)
        btb[i] <= '0;
    end else if (ex_valid && (ex_taken || !ex_cond)) begin
      btb[ex_pc[BTB_IDX_W+1:2]] <= '{valid:  1'b1,
                                     tag:    ex_pc[TAG_HI:TAG_LO],
                                     target: ex_tg_pc};
    end
  end

  // a repair wins over the speculative shift of the same cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      ghr <= '0;
    else if (ex_mispredict)
      ghr <= ex_cond ? {ex_ghr[GHR_W-2:0], ex_taken} : ex_ghr;
    else if (if_valid && if_cond_br)
      ghr <= {ghr[GHR_W-2:0], pred_dir};
  end

endmodule

// File: tb/tb_bp_gshare.sv
// Self-checking bench for bp_gshare: directed steps, then random traffic
// checked against a table-level reference model of the predictor.
module tb_bp_gshare;
  import bp_gshare_pkg::*;

  localparam int RAS_D = 4;

  logic            clock = 1'b0;
  logic            reset;
  logic            if_valid, if_cond_br, if_jump, if_call, if_ret;
  logic [XLEN-1:0] if_pc, ex_pc, ex_tg_pc, bp_pc, bp_npc;
  logic            bp_taken;
  logic [7:0]      bp_ghr, ex_ghr;
  logic            ex_valid, ex_cond, ex_taken, ex_mispredict;

  int n_cmp = 0;
  int n_bad = 0;

  int unsigned m_pht [256];
  bit          m_bv  [32];
  int unsigned m_bt  [32];
  logic [31:0] m_btgt[32];
  int unsigned m_ghr;
  logic [31:0] m_ras [$];

  bp_gshare #(
    .PHT_IDX_W(8), .GHR_W(8), .BTB_IDX_W(5),
    .BTB_TAG_W(10), .RAS_DEPTH(RAS_D)
  ) dut (
    .clock(clock), .reset(reset),
    .if_valid(if_valid), .if_pc(if_pc),
    .if_cond_br(if_cond_br), .if_jump(if_jump),
    .if_call(if_call), .if_ret(if_ret),
    .bp_pc(bp_pc), .bp_npc(bp_npc),
    .bp_taken(bp_taken), .bp_ghr(bp_ghr),
    .ex_valid(ex_valid), .ex_cond(ex_cond), .ex_pc(ex_pc),
    .ex_taken(ex_taken), .ex_tg_pc(ex_tg_pc),
    .ex_ghr(ex_ghr), .ex_mispredict(ex_mispredict)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 256; i++) m_pht[i] = 1;
    for (int i = 0; i < 32; i++) m_bv[i] = 1'b0;
    m_ghr = 0;
    m_ras.delete();
  endtask

  function automatic void m_pred(output logic [31:0] pc, output logic tk);
    int unsigned idx, bi;
    bit hit, jmp, ras;
    pc  = if_pc + 32'd4;
    tk  = 1'b0;
    idx = ((if_pc >> 2) ^ m_ghr) % 256;
    bi  = (if_pc >> 2) % 32;
    hit = m_bv[bi] && (m_bt[bi] == (if_pc >> 7) % 1024);
`ifdef BP_RAS_EN
    ras = if_ret && m_ras.size() > 0;
    jmp = if_jump;
`else
    ras = 1'b0;
    jmp = if_jump || if_ret;
`endif
    if (!if_valid) return;
    if (ras) begin
      pc = m_ras[$];
      tk = 1'b1;
    end else if (hit && (jmp || (if_cond_br && m_pht[idx] >= 2))) begin
      pc = m_btgt[bi];
      tk = 1'b1;
    end
  endfunction

  task automatic m_update();
    int unsigned idx, i, bi;
    bit dir;
    idx = ((if_pc >> 2) ^ m_ghr) % 256;
    dir = m_pht[idx] >= 2;
`ifdef BP_RAS_EN
    if (if_valid) begin
      if (if_ret && m_ras.size() > 0) void'(m_ras.pop_back());
      if (if_call) begin
        m_ras.push_back(if_pc + 32'd4);
        if (m_ras.size() > RAS_D) void'(m_ras.pop_front());
      end
    end
`endif
    if (ex_valid && ex_cond) begin
      i = ((ex_pc >> 2) ^ 32'(ex_ghr)) % 256;
      if (ex_taken) begin
        if (m_pht[i] < 3) m_pht[i] = m_pht[i] + 1;
      end else if (m_pht[i] > 0) begin
        m_pht[i] = m_pht[i] - 1;
      end
    end
    if (ex_valid && (ex_taken || !ex_cond)) begin
      bi = (ex_pc >> 2) % 32;
      m_bv[bi]   = 1'b1;
      m_bt[bi]   = (ex_pc >> 7) % 1024;
      m_btgt[bi] = ex_tg_pc;
    end
    if (ex_mispredict)
      m_ghr = ex_cond ? (32'(ex_ghr) * 2 + 32'(ex_taken)) % 256 : 32'(ex_ghr);
    else if (if_valid && if_cond_br)
      m_ghr = (m_ghr * 2 + 32'(dir)) % 256;
  endtask

  task automatic idle();
    if_valid = 0; if_cond_br = 0; if_jump = 0; if_call = 0; if_ret = 0;
    if_pc = '0; ex_valid = 0; ex_cond = 0; ex_pc = '0; ex_taken = 0;
    ex_tg_pc = '0; ex_ghr = '0; ex_mispredict = 0;
  endtask

  // inputs are set at a falling edge; check, clock, advance model
  task automatic step();
    logic [31:0] epc;
    logic        etk;
    #1;
    m_pred(epc, etk);
    chk("bp_pc", bp_pc, epc);
    chk("bp_npc", bp_npc, epc + 32'd4);
    chk("bp_taken", 32'(bp_taken), 32'(etk));
    chk("bp_ghr", 32'(bp_ghr), m_ghr);
    @(posedge clock);
    m_update();
    @(negedge clock);
  endtask

  task automatic train(input logic [31:0] pc, input logic tk);
    idle();
    ex_valid = 1; ex_cond = 1; ex_pc = pc; ex_taken = tk;
    ex_tg_pc = 32'h500;
    step();
  endtask

  task automatic repair0();
    idle();
    ex_mispredict = 1;
    step();
  endtask

  task automatic probe(input string tag, input logic [31:0] pc,
                       input logic tk, input logic [31:0] tgt);
    idle();
    if_valid = 1; if_cond_br = 1; if_pc = pc;
    #1;
    chk({tag, "_taken"}, 32'(bp_taken), 32'(tk));
    chk({tag, "_pc"}, bp_pc, tgt);
    step();
  endtask

  task automatic ret_chk(input string tag, input logic [31:0] exp,
                         input logic tk);
    idle();
    if_valid = 1; if_ret = 1; if_pc = 32'h600;
    #1;
    chk(tag, bp_pc, exp);
    chk({tag, "_taken"}, 32'(bp_taken), 32'(tk));
    step();
  endtask

  function automatic logic [31:0] pick_pc();
    logic [31:0] base;
    base = ($urandom_range(0, 1) == 1) ? 32'h1000 : 32'h2000;
    return base + 32'(4 * $urandom_range(0, 15));
  endfunction

  task automatic rnd_cycle();
    if_valid      = $urandom_range(0, 3) != 0;
    if_pc         = pick_pc();
    if_cond_br    = 1'($urandom_range(0, 1));
    if_jump       = $urandom_range(0, 3) == 0;
    if_call       = $urandom_range(0, 3) == 0;
    if_ret        = $urandom_range(0, 3) == 0;
    ex_valid      = 1'($urandom_range(0, 1));
    ex_cond       = 1'($urandom_range(0, 1));
    ex_pc         = pick_pc();
    ex_taken      = 1'($urandom_range(0, 1));
    ex_tg_pc      = $urandom & 32'hFFFF_FFFC;
    ex_ghr        = 8'($urandom_range(0, 3));
    ex_mispredict = $urandom_range(0, 7) == 0;
    step();
  endtask

  task automatic reset_chk();
    #2;
    reset = 1;
    #1;
    chk("rst_pc", bp_pc, if_pc + 32'd4);
    chk("rst_taken", 32'(bp_taken), 32'd0);
    chk("rst_ghr", 32'(bp_ghr), 32'd0);
    m_reset();
    @(negedge clock);
    reset = 0;
  endtask

  initial begin
    idle();
    m_reset();
    reset = 1;
    if_valid = 1; if_cond_br = 1; if_pc = 32'h100;
    repeat (2) @(negedge clock);
    reset = 0;

    // first fetch after reset
    #1;
    chk("t1_pc", bp_pc, 32'h104);
    chk("t1_npc", bp_npc, 32'h108);
    chk("t1_taken", 32'(bp_taken), 32'd0);
    chk("t1_ghr", 32'(bp_ghr), 32'd0);
    step();

    // two taken resolutions make 0x200 predict its target
    idle();
    ex_valid = 1; ex_cond = 1; ex_pc = 32'h200;
    ex_taken = 1; ex_tg_pc = 32'h300;
    step();
    step();
    repair0();
    probe("t2", 32'h200, 1'b1, 32'h300);

    // counter saturation at 0 and 3
    idle();
    ex_valid = 1; ex_cond = 0; ex_pc = 32'h240;
    ex_taken = 1; ex_tg_pc = 32'h500;
    step();
    repeat (5) train(32'h240, 1'b0);
    repair0();
    probe("sat0_a", 32'h240, 1'b0, 32'h244);
    train(32'h240, 1'b1);
    repair0();
    probe("sat0_b", 32'h240, 1'b0, 32'h244);
    repeat (3) train(32'h240, 1'b1);
    repair0();
    probe("sat3_a", 32'h240, 1'b1, 32'h500);
    train(32'h240, 1'b0);
    repair0();
    probe("sat3_b", 32'h240, 1'b1, 32'h500);

    // repair beats a same-cycle speculative shift
    idle();
    if_valid = 1; if_cond_br = 1; if_pc = 32'h240;
    ex_mispredict = 1; ex_cond = 1; ex_taken = 1; ex_ghr = 8'h0F;
    step();
    idle();
    #1;
    chk("t4_ghr", 32'(bp_ghr), 32'h1F);
    step();

`ifdef BP_RAS_EN
    idle();
    if_valid = 1; if_call = 1; if_pc = 32'h400;
    step();
    if_pc = 32'h500;
    step();
    ret_chk("ras_r1", 32'h504, 1'b1);
    ret_chk("ras_r2", 32'h404, 1'b1);
    ret_chk("ras_r3", 32'h604, 1'b0);

    for (int k = 0; k < 5; k++) begin
      idle();
      if_valid = 1; if_call = 1; if_pc = 32'h1000 + 32'(k * 16);
      step();
    end
    for (int k = 4; k >= 1; k--)
      ret_chk("ras_ovf", 32'h1004 + 32'(k * 16), 1'b1);
    ret_chk("ras_lost", 32'h604, 1'b0);
`endif

    repeat (1000) rnd_cycle();
    if_valid = 1; if_pc = pick_pc();
    reset_chk();
    repeat (1000) rnd_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
